// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DIVIDENDLEN = 16;
  localparam int DEF_DIVISORLEN  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DEF_DIVIDENDLEN-1:0] dividend;
    logic [DEF_DIVISORLEN-1:0]  divisor;
  } div_req_t;

  typedef struct packed {
    logic [DEF_DIVIDENDLEN-1:0] quotient;
    logic [DEF_DIVISORLEN-1:0]  remainder;
    logic                       div_by_zero;
  } div_rsp_t;

endpackage

// File: rtl/div_step_unit.sv
// One restoring-division step: trial-subtract (d << k) from w, keep it on no borrow.
module div_step_unit
  import div_pkg::*;
#(
  parameter  int DIVIDENDLEN = DEF_DIVIDENDLEN,
  parameter  int DIVISORLEN  = DEF_DIVISORLEN,
  localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1,
  localparam int KW          = $clog2(DIVIDENDLEN)
) (
  input  logic [DATAPATHLEN-1:0] w,
  input  logic [DIVISORLEN-1:0]  d,
  input  logic [KW-1:0]          k,
  output logic [DATAPATHLEN-1:0] w_next,
  output logic                   qbit
);

  logic [DATAPATHLEN-1:0] shifted;
  logic [DATAPATHLEN:0]   diff;

  // Carry-out of w + ~shifted + 1 is the inverted borrow of w - shifted.
  always_comb begin
    shifted = DATAPATHLEN'(d) << k;
    diff    = {1'b0, w} + {1'b0, ~shifted} + {{DATAPATHLEN{1'b0}}, 1'b1};
    qbit    = diff[DATAPATHLEN];
    w_next  = qbit ? diff[DATAPATHLEN-1:0] : w;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for unsigned restoring division, one quotient bit per cycle, MSB first.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int DIVIDENDLEN = DEF_DIVIDENDLEN,
  parameter int DIVISORLEN  = DEF_DIVISORLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder,
  output logic                   div_by_zero,
  output logic                   busy
);

  localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;
  localparam int KW          = $clog2(DIVIDENDLEN);

  div_state_e             state;
  logic [DATAPATHLEN-1:0] w;
  logic [DIVISORLEN-1:0]  d;
  logic [DIVIDENDLEN-1:0] q;
  logic [DIVISORLEN-1:0]  rem;
  logic                   dbz;
  logic [KW-1:0]          k;
  logic [DATAPATHLEN-1:0] w_next;
  logic                   qbit;

  div_step_unit #(
    .DIVIDENDLEN (DIVIDENDLEN),
    .DIVISORLEN  (DIVISORLEN)
  ) u_step (
    .w      (w),
    .d      (d),
    .k      (k),
    .w_next (w_next),
    .qbit   (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
      d     <= '0;
      q     <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w <= DATAPATHLEN'(dividend);
            d <= divisor;
            k <= KW'(DIVIDENDLEN - 1);
            if (divisor == '0) begin
              q     <= '1;
              rem   <= '0;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              q     <= '0;
              dbz   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          w    <= w_next;
          q[k] <= qbit;
          // k==0 exits before the decrement, so the counter never wraps.
          if (k == '0) begin
            rem   <= w_next[DIVISORLEN-1:0];
            state <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes expected results, a monitor pops on handshake.
module tb_div_seq_ctrl;
  import div_pkg::*;

  typedef struct packed {
    div_req_t req;
    div_rsp_t rsp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        busy;

  int total = 0;
  int bad   = 0;
  sb_entry_t sb[$];
  bit rand_mode = 1'b0;
  bit rdy_fixed = 1'b1;

  div_seq_ctrl #(
    .DIVIDENDLEN (16),
    .DIVISORLEN  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Single driver of out_ready, applied 2 time units after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0d expected no result", quotient, remainder, div_by_zero);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.rsp.quotient));
        check("remainder", 32'(remainder), 32'(e.rsp.remainder));
        check("div_by_zero", 32'(div_by_zero), 32'(e.rsp.div_by_zero));
        if (!e.rsp.div_by_zero) begin
          check("inv_product", 32'(quotient) * 32'(e.req.divisor) + 32'(remainder), 32'(e.req.dividend));
          check("inv_rem_lt_div", 32'(remainder < e.req.divisor), 32'd1);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq, input logic [7:0] er, input logic edbz);
    sb_entry_t e;
    e.req.dividend     = a;
    e.req.divisor      = b;
    e.rsp.quotient     = eq;
    e.rsp.remainder    = er;
    e.rsp.div_by_zero  = edbz;
    sb.push_back(e);
  endtask

  // Presents a request, pushes the expectation just before the accepting edge, then scrambles inputs.
  task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq, input logic [7:0] er, input logic edbz);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    push_exp(a, b, eq, er, edbz);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1000 / 7: out_valid 16 edges after the accepting edge, IDLE after the handshake
    send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    wait_out(lat);
    check("lat_normal", 32'(lat), 32'd16);
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    send(16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0);
    drain();
    send(16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
    drain();

    // divide by zero: result presented in the cycle after accept
    send(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1);
    wait_out(lat);
    check("lat_dbz", 32'(lat), 32'd0);
    drain();

    // backpressure: result held 10 cycles, pending request refused until handshake
    rdy_fixed = 1'b0;
    @(posedge clk);
    #3;
    send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'd16);
    dividend = 16'd200;
    divisor  = 8'd13;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'd142);
      check("bp_remainder", 32'(remainder), 32'd6);
      check("bp_dbz", 32'(div_by_zero), 32'd0);
    end
    rdy_fixed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    push_exp(16'd200, 8'd13, 16'd15, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    check("bp_pending_accepted", 32'(busy), 32'd1);
    check("bp_pending_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();

    // asynchronous reset at step 8 of a 1000/7 run discards the in-flight result
    send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd200, 8'd13, 16'd15, 8'd5, 1'b0);
    wait_out(lat);
    check("arst_next_lat", 32'(lat), 32'd16);
    drain();

    // random traffic with random backpressure, mostly nonzero divisors
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = ($urandom_range(0, 99) < 5) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) send(a, b, 16'hFFFF, 8'd0, 1'b1);
      else           send(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
    end
    rand_mode = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
